// File: rtl/fetch_mem_arbiter.sv
// Shares one single-port, variable-latency RAM between instruction fetch and the data-memory stage.
// MEM wins arbitration, but a streak limit guarantees a waiting fetch is eventually granted.
module fetch_mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_MEM_STREAK = 4,
  parameter int STREAK_W       = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              if_freeze,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_freeze,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack
);

  localparam logic [STREAK_W-1:0] LP_MAX_STREAK = STREAK_W'(MAX_MEM_STREAK);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SERVE_MEM,
    S_SERVE_IF,
    S_RESP_MEM,
    S_RESP_IF
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [STREAK_W-1:0] r_streak;
  logic                r_ram_we;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_wdata;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_mem_rdata;
  logic                w_memreq;
  logic                w_grant_mem;
  logic                w_grant_if;

  assign w_memreq = mem_rd | mem_wr;

  // Arbitration only happens in IDLE; the response cycle lets requesters advance first.
  always_comb begin
    w_grant_mem = 1'b0;
    w_grant_if  = 1'b0;
    if (r_state == S_IDLE) begin
      if (w_memreq && (!if_req || (r_streak < LP_MAX_STREAK))) begin
        w_grant_mem = 1'b1;
      end else if (if_req) begin
        w_grant_if = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_mem) begin
          w_state_nxt = S_SERVE_MEM;
        end else if (w_grant_if) begin
          w_state_nxt = S_SERVE_IF;
        end
      end
      S_SERVE_MEM: if (ram_ack) w_state_nxt = S_RESP_MEM;
      S_SERVE_IF:  if (ram_ack) w_state_nxt = S_RESP_IF;
      S_RESP_MEM:  w_state_nxt = S_IDLE;
      S_RESP_IF:   w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ram_req   = (r_state == S_SERVE_MEM) || (r_state == S_SERVE_IF);
    mem_ready = (r_state == S_RESP_MEM);
    if_ready  = (r_state == S_RESP_IF);
  end

  // RAM-side request registers are loaded only on a grant, so they hold through wait states.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else if (w_grant_mem) begin
      r_ram_we    <= mem_wr;
      r_ram_addr  <= mem_addr;
      r_ram_wdata <= mem_wdata;
    end else if (w_grant_if) begin
      r_ram_we    <= 1'b0;
      r_ram_addr  <= if_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else begin
      if ((r_state == S_SERVE_IF) && ram_ack) begin
        r_if_rdata <= ram_rdata;
      end
      if ((r_state == S_SERVE_MEM) && ram_ack && !r_ram_we) begin
        r_mem_rdata <= ram_rdata;
      end
    end
  end

  // Streak counts MEM grants made while a fetch is waiting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_streak <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_grant_if || !if_req) begin
        r_streak <= '0;
      end else if (w_grant_mem && (r_streak != LP_MAX_STREAK)) begin
        r_streak <= r_streak + STREAK_W'(1);
      end
    end
  end

  assign ram_we     = r_ram_we;
  assign ram_addr   = r_ram_addr;
  assign ram_wdata  = r_ram_wdata;
  assign if_rdata   = r_if_rdata;
  assign mem_rdata  = r_mem_rdata;
  assign if_freeze  = if_req & ~if_ready;
  assign mem_freeze = w_memreq & ~mem_ready;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Bench for fetch_mem_arbiter: a RAM responder with programmable wait states plus
// scoreboard queues of expected read data and expected RAM grants.
module tb_fetch_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
  } gnt_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              if_freeze;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              mem_freeze;
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic              ram_ack = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_if_q[$];
  logic [31:0] exp_mem_q[$];
  gnt_t        exp_gnt_q[$];
  gnt_t        gnt_q[$];

  fetch_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_MEM_STREAK(4), .STREAK_W(3)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ready(if_ready), .if_freeze(if_freeze),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_freeze(mem_freeze),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack)
  );

  always #5 clk = ~clk;

  // Initial RAM contents: a fixed pattern, with one real instruction word at 0x40.
  function automatic logic [31:0] ram_init(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C22_0004;
    return a ^ 32'h5A00_00C3;
  endfunction

  // RAM responder: acks after ack_dly wait cycles, drives inputs on the falling edge.
  int          ack_dly  = 0;
  int          wait_cnt = 0;
  logic [31:0] ram_mem [256];
  logic [255:0] ram_vld = '0;
  logic        prev_req = 1'b0;

  always @(negedge clk) begin
    if (ram_req) begin
      if (wait_cnt >= ack_dly) begin
        ram_ack  <= 1'b1;
        wait_cnt <= 0;
        if (ram_we) begin
          ram_mem[ram_addr[9:2]] <= ram_wdata;
          ram_vld[ram_addr[9:2]] <= 1'b1;
        end else begin
          ram_rdata <= ram_vld[ram_addr[9:2]] ? ram_mem[ram_addr[9:2]] : ram_init(ram_addr);
        end
      end else begin
        ram_ack  <= 1'b0;
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      ram_ack  <= 1'b0;
      wait_cnt <= 0;
    end
  end

  // Grant monitor: records every new RAM request.
  always @(negedge clk) begin
    prev_req <= ram_req;
    if (ram_req && !prev_req) gnt_q.push_back({ram_we, ram_addr});
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready(input bit is_mem, input int max_cyc, output int cyc, output bit seen);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      seen = is_mem ? mem_ready : if_ready;
    end
  endtask

  task automatic test_reset();
    bit busy;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (ram_req !== 1'b0) begin n_fail++; $display("FAIL rst_ram_req: got %b want 0", ram_req); end
    n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rst_ram_we: got %b want 0", ram_we); end
    n_checks++; if ({if_ready, mem_ready} !== 2'b00) begin n_fail++; $display("FAIL rst_ready: got %b want 00", {if_ready, mem_ready}); end
    n_checks++; if (ram_addr !== 32'h0) begin n_fail++; $display("FAIL rst_ram_addr: got %h want 0", ram_addr); end
    n_checks++; if ({if_rdata, mem_rdata} !== 64'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", {if_rdata, mem_rdata}); end
    rst     = 1'b1;
    ack_dly = 20;
    if_req  = 1'b1;
    if_addr = 32'h40;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (ram_req !== 1'b1) begin n_fail++; $display("FAIL rst_pre_serve: got ram_req=%b want 1", ram_req); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (ram_req !== 1'b0) begin n_fail++; $display("FAIL rst_abort_req: got %b want 0", ram_req); end
    @(negedge clk);
    rst    = 1'b1;
    if_req = 1'b0;
    busy   = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (if_ready || mem_ready || ram_req) busy = 1'b1;
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_no_pulse: got activity=%b want 0", busy); end
    n_checks++; if (if_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_if_rdata: got %h want 0", if_rdata); end
    ack_dly = 0;
    gnt_q.delete();
  endtask

  task automatic test_if_only();
    logic [31:0] e;
    exp_if_q.push_back(32'h8C22_0004);
    if_req  = 1'b1;
    if_addr = 32'h40;
    #1;
    n_checks++; if (if_freeze !== 1'b1) begin n_fail++; $display("FAIL if_freeze_c0: got %b want 1", if_freeze); end
    @(negedge clk);
    n_checks++; if ({ram_req, ram_we, if_ready, if_freeze} !== 4'b1001) begin n_fail++; $display("FAIL if_c1_ctrl: got req/we/rdy/frz=%b want 1001", {ram_req, ram_we, if_ready, if_freeze}); end
    n_checks++; if (ram_addr !== 32'h40) begin n_fail++; $display("FAIL if_c1_addr: got %h want 00000040", ram_addr); end
    @(negedge clk);
    n_checks++; if ({if_ready, if_freeze} !== 2'b10) begin n_fail++; $display("FAIL if_c2_ready: got rdy/frz=%b want 10", {if_ready, if_freeze}); end
    e = exp_if_q.pop_front();
    n_checks++; if (if_rdata !== e) begin n_fail++; $display("FAIL if_rdata: got %h want %h", if_rdata, e); end
    if_req = 1'b0;
    @(negedge clk);
    n_checks++; if ({if_ready, ram_req} !== 2'b00) begin n_fail++; $display("FAIL if_pulse_end: got rdy/req=%b want 00", {if_ready, ram_req}); end
    gnt_q.delete();
  endtask

  task automatic test_simultaneous();
    int   cyc = 0, order = 0, mem_ord = -1, if_ord = -1;
    bit   frz_bad = 1'b0;
    logic [31:0] e;
    gnt_t eg, ag;
    exp_mem_q.push_back(ram_init(32'h100));
    exp_if_q.push_back(ram_init(32'h44));
    exp_gnt_q.push_back({1'b0, 32'h100});
    exp_gnt_q.push_back({1'b0, 32'h44});
    if_req   = 1'b1;
    if_addr  = 32'h44;
    mem_rd   = 1'b1;
    mem_addr = 32'h100;
    while ((mem_ord < 0 || if_ord < 0) && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (mem_ready) begin
        e = exp_mem_q.pop_front();
        n_checks++; if (mem_rdata !== e) begin n_fail++; $display("FAIL sim_mem_rdata: got %h want %h", mem_rdata, e); end
        mem_rd  = 1'b0;
        mem_ord = order++;
      end
      if (if_ready) begin
        e = exp_if_q.pop_front();
        n_checks++; if (if_rdata !== e) begin n_fail++; $display("FAIL sim_if_rdata: got %h want %h", if_rdata, e); end
        if_req = 1'b0;
        if_ord = order++;
      end else if (if_req && !if_freeze) begin
        frz_bad = 1'b1;
      end
    end
    n_checks++; if (mem_ord !== 0 || if_ord !== 1) begin n_fail++; $display("FAIL sim_order: got mem=%0d if=%0d want mem=0 if=1", mem_ord, if_ord); end
    n_checks++; if (frz_bad !== 1'b0) begin n_fail++; $display("FAIL sim_if_freeze: got dropped=%b want 0", frz_bad); end
    repeat (2) @(negedge clk);
    n_checks++; if (gnt_q.size() != exp_gnt_q.size()) begin n_fail++; $display("FAIL sim_gnt_count: got %0d want %0d", gnt_q.size(), exp_gnt_q.size()); end
    while (exp_gnt_q.size() > 0 && gnt_q.size() > 0) begin
      eg = exp_gnt_q.pop_front();
      ag = gnt_q.pop_front();
      n_checks++; if (ag !== eg) begin n_fail++; $display("FAIL sim_gnt: got %h want %h", ag, eg); end
    end
    exp_gnt_q.delete();
    gnt_q.delete();
  endtask

  task automatic test_starvation();
    int   cyc = 0, k = 0, ifn = 0;
    logic [31:0] e;
    gnt_t eg, ag;
    for (int i = 0; i < 10; i++) begin
      exp_gnt_q.push_back({1'b1, 32'h200 + 32'(4 * i)});
      if (i == 3) exp_gnt_q.push_back({1'b0, 32'h80});
      if (i == 7) exp_gnt_q.push_back({1'b0, 32'h84});
    end
    exp_if_q.push_back(ram_init(32'h80));
    exp_if_q.push_back(ram_init(32'h84));
    mem_wr    = 1'b1;
    mem_addr  = 32'h200;
    mem_wdata = 32'hA000_0000;
    if_req    = 1'b1;
    if_addr   = 32'h80;
    while ((k < 10 || ifn < 2) && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (mem_ready) begin
        k++;
        if (k < 10) begin
          mem_addr  = 32'h200 + 32'(4 * k);
          mem_wdata = 32'hA000_0000 + 32'(k);
        end else begin
          mem_wr = 1'b0;
        end
      end
      if (if_ready) begin
        e = exp_if_q.pop_front();
        n_checks++; if (if_rdata !== e) begin n_fail++; $display("FAIL starve_if_rdata: got %h want %h", if_rdata, e); end
        ifn++;
        if (ifn < 2) if_addr = 32'h84;
        else         if_req  = 1'b0;
      end
    end
    n_checks++; if (cyc >= 300) begin n_fail++; $display("FAIL starve_timeout: got %0d cycles want <300", cyc); end
    repeat (2) @(negedge clk);
    n_checks++; if (gnt_q.size() != exp_gnt_q.size()) begin n_fail++; $display("FAIL starve_gnt_count: got %0d want %0d", gnt_q.size(), exp_gnt_q.size()); end
    for (int i = 0; exp_gnt_q.size() > 0 && gnt_q.size() > 0; i++) begin
      eg = exp_gnt_q.pop_front();
      ag = gnt_q.pop_front();
      n_checks++; if (ag !== eg) begin n_fail++; $display("FAIL starve_gnt%0d: got %h want %h", i, ag, eg); end
    end
    exp_gnt_q.delete();
    gnt_q.delete();
  endtask

  task automatic test_wait_states();
    int cyc = 0, req_cyc = 0;
    bit seen, unstable = 1'b0, frz_bad = 1'b0;
    ack_dly   = 5;
    mem_wr    = 1'b1;
    mem_addr  = 32'h300;
    mem_wdata = 32'hCAFE_F00D;
    seen      = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ram_req) begin
        req_cyc++;
        if (ram_addr !== 32'h300 || ram_wdata !== 32'hCAFE_F00D || ram_we !== 1'b1) unstable = 1'b1;
      end
      seen = mem_ready;
      if (!seen && !mem_freeze) frz_bad = 1'b1;
    end
    n_checks++; if (cyc !== 7) begin n_fail++; $display("FAIL ws_wr_latency: got %0d want 7", cyc); end
    n_checks++; if (req_cyc !== 6) begin n_fail++; $display("FAIL ws_req_cycles: got %0d want 6", req_cyc); end
    n_checks++; if (unstable !== 1'b0) begin n_fail++; $display("FAIL ws_ram_stable: got unstable=%b want 0", unstable); end
    n_checks++; if ({frz_bad, mem_freeze} !== 2'b00) begin n_fail++; $display("FAIL ws_mem_freeze: got %b want 00", {frz_bad, mem_freeze}); end
    n_checks++; if (mem_rdata !== ram_init(32'h100)) begin n_fail++; $display("FAIL ws_wr_keeps_rdata: got %h want %h", mem_rdata, ram_init(32'h100)); end
    mem_wr = 1'b0;
    exp_mem_q.push_back(32'hCAFE_F00D);
    @(negedge clk);
    mem_rd = 1'b1;
    wait_ready(1'b1, 40, cyc, seen);
    n_checks++; if (!seen || cyc !== 7) begin n_fail++; $display("FAIL ws_rd_latency: got %0d seen=%b want 7", cyc, seen); end
    n_checks++; if (mem_rdata !== exp_mem_q[0]) begin n_fail++; $display("FAIL ws_rd_rdata: got %h want %h", mem_rdata, exp_mem_q[0]); end
    void'(exp_mem_q.pop_front());
    mem_rd  = 1'b0;
    ack_dly = 0;
    @(negedge clk);
    gnt_q.delete();
  endtask

  task automatic test_rd_wr();
    int cyc;
    bit seen;
    mem_rd    = 1'b1;
    mem_wr    = 1'b1;
    mem_addr  = 32'h304;
    mem_wdata = 32'h1234_5678;
    @(negedge clk);
    n_checks++; if ({ram_req, ram_we} !== 2'b11) begin n_fail++; $display("FAIL rdwr_we: got req/we=%b want 11", {ram_req, ram_we}); end
    n_checks++; if (ram_wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rdwr_wdata: got %h want 12345678", ram_wdata); end
    @(negedge clk);
    n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL rdwr_ready: got %b want 1", mem_ready); end
    n_checks++; if (mem_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rdwr_rdata_hold: got %h want cafef00d", mem_rdata); end
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    @(negedge clk);
    exp_mem_q.push_back(32'h1234_5678);
    mem_rd = 1'b1;
    wait_ready(1'b1, 20, cyc, seen);
    n_checks++; if (!seen || cyc !== 2) begin n_fail++; $display("FAIL rdwr_readback_lat: got %0d seen=%b want 2", cyc, seen); end
    n_checks++; if (mem_rdata !== exp_mem_q[0]) begin n_fail++; $display("FAIL rdwr_readback: got %h want %h", mem_rdata, exp_mem_q[0]); end
    void'(exp_mem_q.pop_front());
    mem_rd = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    @(negedge clk);
    test_reset();
    test_if_only();
    test_simultaneous();
    test_starvation();
    test_wait_states();
    test_rd_wr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
